// File: rtl/filter_pkg.sv
// Shared types for the filter result path: pixel word, buffer FSM states, default depth.
package filter_pkg;

   typedef logic [31:0] pixel_t;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      CAPTURE = 2'd1,
      DRAIN   = 2'd2
   } rsb_state_t;

   localparam int RSB_DEFAULT_DEPTH = 8;

endpackage

// File: rtl/result_fifo.sv
// First-word-fall-through FIFO: head word is always on rd_data, pointers wrap modulo DEPTH.
module result_fifo
   import filter_pkg::*;
#(
   parameter int DEPTH = RSB_DEFAULT_DEPTH,
   parameter int AW    = $clog2(DEPTH)
) (
   input  logic          clk,
   input  logic          n_rst,
   input  logic          push,
   input  logic          pop,
   input  pixel_t        wr_data,
   output pixel_t        rd_data,
   output logic          full,
   output logic          empty,
   output logic [AW:0]   count
);

   pixel_t          mem [DEPTH];
   logic [AW-1:0]   wr_ptr;
   logic [AW-1:0]   rd_ptr;
   logic            do_push;
   logic            do_pop;

   assign full    = (count == (AW+1)'(DEPTH));
   assign empty   = (count == '0);
   assign do_push = push && !full;
   assign do_pop  = pop && !empty;
   assign rd_data = mem[rd_ptr];

   // Storage is deliberately left out of reset; only the bookkeeping is cleared.
   always_ff @(posedge clk) begin
      if (do_push) begin
         mem[wr_ptr] <= wr_data;
      end
   end

   always_ff @(posedge clk) begin
      if (!n_rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) begin
            wr_ptr <= wr_ptr + AW'(1);
         end
         if (do_pop) begin
            rd_ptr <= rd_ptr + AW'(1);
         end
         case ({do_push, do_pop})
            2'b10:   count <= count + (AW+1)'(1);
            2'b01:   count <= count - (AW+1)'(1);
            default: count <= count;
         endcase
      end
   end

endmodule

// File: rtl/result_stream_buffer.sv
// Frame-oriented result buffer between the filter and PCIe TX.
// Optional dropped-word counter port enabled by defining RESULT_BUF_DROP_CNT_EN.
module result_stream_buffer
   import filter_pkg::*;
#(
   parameter int DEPTH = RSB_DEFAULT_DEPTH,
   parameter int CNT_W = 16
) (
   input  logic             clk,
   input  logic             n_rst,
   input  logic             frame_start,
   input  logic [CNT_W-1:0] frame_words,
   input  logic             in_valid,
   input  pixel_t           in_data,
   output logic             in_ready,
   output logic             out_valid,
   output pixel_t           out_data,
   input  logic             out_ready,
   output logic             busy,
`ifdef RESULT_BUF_DROP_CNT_EN
   output logic             frame_done,
   output logic [15:0]      drop_cnt
`else
   output logic             frame_done
`endif
);

   localparam int AW = $clog2(DEPTH);

   rsb_state_t       state;
   logic [CNT_W-1:0] words_left;
   logic             push;
   logic             pop;
   logic             full;
   logic             empty;
   logic [AW:0]      count;
   logic             drain_empty;

   assign in_ready  = (state == CAPTURE) && !full;
   assign out_valid = !empty;
   assign push      = in_valid && in_ready;
   assign pop       = out_valid && out_ready;
   assign busy      = (state != IDLE);

   // Nothing is pushed while draining, so the FIFO is empty after this edge
   // when it already is, or when the last word leaves now.
   assign drain_empty = empty || ((count == (AW+1)'(1)) && pop);

   result_fifo #(
      .DEPTH (DEPTH),
      .AW    (AW)
   ) u_fifo (
      .clk     (clk),
      .n_rst   (n_rst),
      .push    (push),
      .pop     (pop),
      .wr_data (in_data),
      .rd_data (out_data),
      .full    (full),
      .empty   (empty),
      .count   (count)
   );

   always_ff @(posedge clk) begin
      if (!n_rst) begin
         state      <= IDLE;
         words_left <= '0;
         frame_done <= 1'b0;
      end else begin
         frame_done <= 1'b0;
         case (state)
            IDLE: begin
               if (frame_start) begin
                  words_left <= frame_words;
                  state      <= (frame_words == '0) ? DRAIN : CAPTURE;
               end
            end
            CAPTURE: begin
               if (push) begin
                  words_left <= words_left - CNT_W'(1);
                  if (words_left == CNT_W'(1)) begin
                     state <= DRAIN;
                  end
               end
            end
            DRAIN: begin
               if (drain_empty) begin
                  frame_done <= 1'b1;
                  state      <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

`ifdef RESULT_BUF_DROP_CNT_EN
   logic drop;
   assign drop = in_valid && !in_ready;

   // A frame start clears the count, but a drop on that same edge still counts.
   always_ff @(posedge clk) begin
      if (!n_rst) begin
         drop_cnt <= '0;
      end else if ((state == IDLE) && frame_start) begin
         drop_cnt <= drop ? 16'd1 : 16'd0;
      end else if (drop && (drop_cnt != 16'hFFFF)) begin
         drop_cnt <= drop_cnt + 16'd1;
      end
   end
`endif

endmodule

// File: tb/tb_result_stream_buffer.sv
// Self-checking bench for result_stream_buffer; a behavioural model feeds an expected-word queue.
// Drop counter checks are active when RESULT_BUF_DROP_CNT_EN is defined.
module tb_result_stream_buffer;
   import filter_pkg::*;

   localparam int DEPTH = 8;
   localparam int CNT_W = 16;

   logic             clk;
   logic             n_rst;
   logic             frame_start;
   logic [CNT_W-1:0] frame_words;
   logic             in_valid;
   pixel_t           in_data;
   logic             in_ready;
   logic             out_valid;
   pixel_t           out_data;
   logic             out_ready;
   logic             busy;
   logic             frame_done;
`ifdef RESULT_BUF_DROP_CNT_EN
   logic [15:0]      drop_cnt;
`endif

   int vectors = 0;
   int fails   = 0;

   // reference model
   pixel_t q[$];
   int     m_state = 0;
   int     m_left  = 0;
   bit     m_done  = 1'b0;
   int     m_drop  = 0;

   result_stream_buffer #(
      .DEPTH (DEPTH),
      .CNT_W (CNT_W)
   ) dut (
      .clk         (clk),
      .n_rst       (n_rst),
      .frame_start (frame_start),
      .frame_words (frame_words),
      .in_valid    (in_valid),
      .in_data     (in_data),
      .in_ready    (in_ready),
      .out_valid   (out_valid),
      .out_data    (out_data),
      .out_ready   (out_ready),
      .busy        (busy),
`ifdef RESULT_BUF_DROP_CNT_EN
      .frame_done  (frame_done),
      .drop_cnt    (drop_cnt)
`else
      .frame_done  (frame_done)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic bit exp_ready();
      return (m_state == 1) && (q.size() < DEPTH);
   endfunction

   // Update the model for the coming edge from the current inputs, then step past it.
   task automatic advance();
      bit rdy;
      bit push;
      bit pop;
      int old_state;
      rdy       = exp_ready();
      push      = in_valid && rdy;
      pop       = (q.size() != 0) && out_ready;
      old_state = m_state;
      if (!n_rst) begin
         q.delete();
         m_state = 0;
         m_left  = 0;
         m_done  = 1'b0;
         m_drop  = 0;
      end else begin
         if (pop) void'(q.pop_front());
         if (push) q.push_back(in_data);
         m_done = 1'b0;
         case (old_state)
            0: if (frame_start) begin
                  m_left  = int'(frame_words);
                  m_state = (frame_words == 0) ? 2 : 1;
               end
            1: if (push) begin
                  m_left--;
                  if (m_left == 0) m_state = 2;
               end
            default: if (q.size() == 0) begin
                  m_done  = 1'b1;
                  m_state = 0;
               end
         endcase
         if (old_state == 0 && frame_start) m_drop = (in_valid && !rdy) ? 1 : 0;
         else if (in_valid && !rdy && m_drop != 16'hFFFF) m_drop++;
      end
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs();
      frame_start = 1'b0;
      frame_words = '0;
      in_valid    = 1'b0;
      in_data     = '0;
      out_ready   = 1'b0;
   endtask

   task automatic test_reset();
      n_rst = 1'b0;
      idle_inputs();
      advance();
      advance();
      @(negedge clk);
      vectors++; if (out_valid !== 1'b0) begin fails++; $display("[TB] FAIL reset out_valid: got %b want 0", out_valid); end
      vectors++; if (in_ready !== 1'b0) begin fails++; $display("[TB] FAIL reset in_ready: got %b want 0", in_ready); end
      vectors++; if (busy !== 1'b0) begin fails++; $display("[TB] FAIL reset busy: got %b want 0", busy); end
      vectors++; if (frame_done !== 1'b0) begin fails++; $display("[TB] FAIL reset frame_done: got %b want 0", frame_done); end
`ifdef RESULT_BUF_DROP_CNT_EN
      vectors++; if (drop_cnt !== 16'd0) begin fails++; $display("[TB] FAIL reset drop_cnt: got %0d want 0", drop_cnt); end
`endif
      n_rst = 1'b1;
      advance();
   endtask

   task automatic test_basic_frame();
      int done_count = 0;
      int pops = 0;
      bit finished = 1'b0;
      for (int c = 0; c < 20 && !finished; c++) begin
         idle_inputs();
         out_ready = 1'b1;
         if (c == 0) begin frame_start = 1'b1; frame_words = 16'd4; end
         if (c >= 1 && c <= 4) begin in_valid = 1'b1; in_data = 32'hA000_0000 + c; end
         @(negedge clk);
         vectors++; if (out_valid !== (q.size() != 0)) begin fails++; $display("[TB] FAIL basic out_valid c%0d: got %b want %b", c, out_valid, q.size() != 0); end
         if (q.size() != 0) begin
            pops++;
            vectors++; if (out_data !== q[0]) begin fails++; $display("[TB] FAIL basic out_data c%0d: got %h want %h", c, out_data, q[0]); end
         end
         vectors++; if (in_ready !== exp_ready()) begin fails++; $display("[TB] FAIL basic in_ready c%0d: got %b want %b", c, in_ready, exp_ready()); end
         vectors++; if (busy !== (m_state != 0)) begin fails++; $display("[TB] FAIL basic busy c%0d: got %b want %b", c, busy, m_state != 0); end
         vectors++; if (frame_done !== m_done) begin fails++; $display("[TB] FAIL basic frame_done c%0d: got %b want %b", c, frame_done, m_done); end
         if (frame_done) done_count++;
         if (m_done) finished = 1'b1;
         else advance();
      end
      vectors++; if (pops !== 4) begin fails++; $display("[TB] FAIL basic word_count: got %0d want 4", pops); end
      vectors++; if (done_count !== 1) begin fails++; $display("[TB] FAIL basic done_pulses: got %0d want 1", done_count); end
      idle_inputs();
      advance();
   endtask

   task automatic test_overflow();
      int ready_seen = 0;
      bit finished = 1'b0;
      for (int c = 0; c < 14; c++) begin
         idle_inputs();
         if (c == 0) begin frame_start = 1'b1; frame_words = 16'd10; end
         if (c >= 1 && c <= 10) begin in_valid = 1'b1; in_data = 32'hB000_0000 + c; end
         @(negedge clk);
         if (c >= 1 && c <= 10 && in_ready) ready_seen++;
         vectors++; if (in_ready !== exp_ready()) begin fails++; $display("[TB] FAIL ovf in_ready c%0d: got %b want %b", c, in_ready, exp_ready()); end
         vectors++; if (out_valid !== (q.size() != 0)) begin fails++; $display("[TB] FAIL ovf out_valid c%0d: got %b want %b", c, out_valid, q.size() != 0); end
         vectors++; if (frame_done !== 1'b0) begin fails++; $display("[TB] FAIL ovf early_done c%0d: got %b want 0", c, frame_done); end
         advance();
      end
      vectors++; if (ready_seen !== 8) begin fails++; $display("[TB] FAIL ovf accepted: got %0d want 8", ready_seen); end
`ifdef RESULT_BUF_DROP_CNT_EN
      @(negedge clk);
      vectors++; if (drop_cnt !== 16'd2) begin fails++; $display("[TB] FAIL ovf drop_cnt: got %0d want 2", drop_cnt); end
`endif
      // full FIFO with simultaneous in_valid and out_ready
      in_valid = 1'b1; in_data = 32'hB000_00FF; out_ready = 1'b1;
      @(negedge clk);
      vectors++; if (in_ready !== 1'b0) begin fails++; $display("[TB] FAIL full_pop in_ready: got %b want 0", in_ready); end
      vectors++; if (out_data !== q[0]) begin fails++; $display("[TB] FAIL full_pop out_data: got %h want %h", out_data, q[0]); end
      advance();
      in_valid = 1'b0; out_ready = 1'b0;
      @(negedge clk);
      vectors++; if (in_ready !== 1'b1) begin fails++; $display("[TB] FAIL full_pop next_ready: got %b want 1", in_ready); end
      vectors++; if (q.size() !== 7) begin fails++; $display("[TB] FAIL full_pop model_count: got %0d want 7", q.size()); end
      vectors++; if (out_data !== 32'hB000_0002) begin fails++; $display("[TB] FAIL full_pop head: got %h want b0000002", out_data); end
      advance();
      for (int c = 0; c < 40 && !finished; c++) begin
         idle_inputs();
         out_ready = 1'b1;
         in_valid  = 1'b1;
         in_data   = 32'hB100_0000 + c;
         @(negedge clk);
         vectors++; if (out_valid !== (q.size() != 0)) begin fails++; $display("[TB] FAIL ovf2 out_valid c%0d: got %b want %b", c, out_valid, q.size() != 0); end
         if (q.size() != 0) begin
            vectors++; if (out_data !== q[0]) begin fails++; $display("[TB] FAIL ovf2 out_data c%0d: got %h want %h", c, out_data, q[0]); end
         end
         vectors++; if (in_ready !== exp_ready()) begin fails++; $display("[TB] FAIL ovf2 in_ready c%0d: got %b want %b", c, in_ready, exp_ready()); end
         vectors++; if (frame_done !== m_done) begin fails++; $display("[TB] FAIL ovf2 frame_done c%0d: got %b want %b", c, frame_done, m_done); end
`ifdef RESULT_BUF_DROP_CNT_EN
         vectors++; if (drop_cnt !== 16'(m_drop)) begin fails++; $display("[TB] FAIL ovf2 drop_cnt c%0d: got %0d want %0d", c, drop_cnt, m_drop); end
`endif
         if (m_done) finished = 1'b1;
         else advance();
      end
      vectors++; if (!finished) begin fails++; $display("[TB] FAIL ovf2 timeout: got no frame_done want frame_done"); end
      idle_inputs();
      advance();
   endtask

   task automatic test_zero_frame();
      for (int c = 0; c < 4; c++) begin
         idle_inputs();
         if (c == 0) begin frame_start = 1'b1; frame_words = 16'd0; in_valid = 1'b1; in_data = 32'hDEAD_0000; end
         @(negedge clk);
         vectors++; if (busy !== (m_state != 0)) begin fails++; $display("[TB] FAIL zero busy c%0d: got %b want %b", c, busy, m_state != 0); end
         vectors++; if (frame_done !== m_done) begin fails++; $display("[TB] FAIL zero frame_done c%0d: got %b want %b", c, frame_done, m_done); end
         vectors++; if (out_valid !== 1'b0) begin fails++; $display("[TB] FAIL zero out_valid c%0d: got %b want 0", c, out_valid); end
`ifdef RESULT_BUF_DROP_CNT_EN
         vectors++; if (drop_cnt !== 16'(m_drop)) begin fails++; $display("[TB] FAIL zero drop_cnt c%0d: got %0d want %0d", c, drop_cnt, m_drop); end
`endif
         if (c == 1) begin
            vectors++; if (busy !== 1'b1) begin fails++; $display("[TB] FAIL zero busy_after1: got %b want 1", busy); end
         end
         if (c == 2) begin
            vectors++; if (frame_done !== 1'b1) begin fails++; $display("[TB] FAIL zero done_after2: got %b want 1", frame_done); end
         end
         advance();
      end
   endtask

   task automatic test_reset_mid_frame();
      bit finished = 1'b0;
      for (int c = 0; c < 6; c++) begin
         idle_inputs();
         if (c == 0) begin frame_start = 1'b1; frame_words = 16'd8; end
         else begin in_valid = 1'b1; in_data = 32'hE000_0000 + c; end
         @(negedge clk);
         vectors++; if (in_ready !== exp_ready()) begin fails++; $display("[TB] FAIL rst_mid in_ready c%0d: got %b want %b", c, in_ready, exp_ready()); end
         advance();
      end
      idle_inputs();
      n_rst = 1'b0;
      @(negedge clk);
      vectors++; if (out_valid !== 1'b1) begin fails++; $display("[TB] FAIL rst_mid buffered: got %b want 1", out_valid); end
      advance();
      n_rst = 1'b1;
      @(negedge clk);
      vectors++; if (out_valid !== 1'b0) begin fails++; $display("[TB] FAIL rst_mid out_valid: got %b want 0", out_valid); end
      vectors++; if (busy !== 1'b0) begin fails++; $display("[TB] FAIL rst_mid busy: got %b want 0", busy); end
      vectors++; if (frame_done !== 1'b0) begin fails++; $display("[TB] FAIL rst_mid frame_done: got %b want 0", frame_done); end
      advance();
      for (int c = 0; c < 20 && !finished; c++) begin
         idle_inputs();
         out_ready = 1'b1;
         if (c == 0) begin frame_start = 1'b1; frame_words = 16'd3; end
         if (c >= 1 && c <= 3) begin in_valid = 1'b1; in_data = 32'hE100_0000 + c; end
         @(negedge clk);
         vectors++; if (out_valid !== (q.size() != 0)) begin fails++; $display("[TB] FAIL rst_new out_valid c%0d: got %b want %b", c, out_valid, q.size() != 0); end
         if (q.size() != 0) begin
            vectors++; if (out_data !== q[0]) begin fails++; $display("[TB] FAIL rst_new out_data c%0d: got %h want %h", c, out_data, q[0]); end
         end
         vectors++; if (busy !== (m_state != 0)) begin fails++; $display("[TB] FAIL rst_new busy c%0d: got %b want %b", c, busy, m_state != 0); end
         vectors++; if (frame_done !== m_done) begin fails++; $display("[TB] FAIL rst_new frame_done c%0d: got %b want %b", c, frame_done, m_done); end
         if (m_done) finished = 1'b1;
         else advance();
      end
      vectors++; if (!finished) begin fails++; $display("[TB] FAIL rst_new timeout: got no frame_done want frame_done"); end
      idle_inputs();
      advance();
   endtask

   task automatic test_wrap();
      int pops = 0;
      bit finished = 1'b0;
      for (int c = 0; c < 120 && !finished; c++) begin
         idle_inputs();
         out_ready = c[0];
         if (c == 0) begin frame_start = 1'b1; frame_words = 16'd12; end
         else begin in_valid = 1'b1; in_data = 32'hC000_0000 + c; end
         @(negedge clk);
         vectors++; if (out_valid !== (q.size() != 0)) begin fails++; $display("[TB] FAIL wrap out_valid c%0d: got %b want %b", c, out_valid, q.size() != 0); end
         if (q.size() != 0) begin
            vectors++; if (out_data !== q[0]) begin fails++; $display("[TB] FAIL wrap out_data c%0d: got %h want %h", c, out_data, q[0]); end
            if (out_ready) pops++;
         end
         vectors++; if (in_ready !== exp_ready()) begin fails++; $display("[TB] FAIL wrap in_ready c%0d: got %b want %b", c, in_ready, exp_ready()); end
         vectors++; if (frame_done !== m_done) begin fails++; $display("[TB] FAIL wrap frame_done c%0d: got %b want %b", c, frame_done, m_done); end
`ifdef RESULT_BUF_DROP_CNT_EN
         vectors++; if (drop_cnt !== 16'(m_drop)) begin fails++; $display("[TB] FAIL wrap drop_cnt c%0d: got %0d want %0d", c, drop_cnt, m_drop); end
`endif
         if (m_done) finished = 1'b1;
         else advance();
      end
      vectors++; if (pops !== 12) begin fails++; $display("[TB] FAIL wrap pops: got %0d want 12", pops); end
      vectors++; if (!finished) begin fails++; $display("[TB] FAIL wrap timeout: got no frame_done want frame_done"); end
      idle_inputs();
      advance();
   endtask

   initial begin
      $display("[TB] result_stream_buffer bench start");
      test_reset();
      test_basic_frame();
      test_overflow();
      test_zero_frame();
      test_reset_mid_frame();
      test_wrap();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
      $finish;
   end

endmodule
